alu_rr_arbiter: RTL and testbench

- Shares one Pre_ALU instance (4-bit; Sel=0 add, Sel=1 AND) between two requesters with round-robin arbitration.
- Each requester uses a valid/ready handshake; the block registers operands, issues them to the ALU, and returns a registered result tagged with the requester id and an add-carry flag.
- At most one operation is in flight; the response side supports backpressure.
- Sits between the two operand sources and the shared ALU datapath.

---
 rtl/alu_pkg.sv | 15 +
 rtl/pre_alu.sv | 20 ++
 rtl/alu_rr_arbiter.sv | 108 ++++++++++
 tb/tb_alu_rr_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state encoding for the arbitrated ALU
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_AND = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_state_e;

endpackage

// File: rtl/pre_alu.sv
// rtl/pre_alu.sv - 4-bit combinational ALU: sel=0 add (wrapping), sel=1 AND
module pre_alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sel,
  output logic [ALU_W-1:0] c
);

  always_comb begin
    c = '0;
    case (sel)
      SEL_ADD: c = a + b;
      SEL_AND: c = a & b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one pre_alu between two
// valid/ready requesters, one operation in flight, registered tagged response
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_W,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sel,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_carry,
  output logic             busy
);

  alu_state_e       state_q;
  alu_state_e       state_d;
  logic             prio_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sel;
  logic             op_id;
  logic [WIDTH-1:0] alu_c;
  logic             add_ovf;
  logic             grant0;
  logic             grant1;

  // Ties go to prio; a lone valid is granted regardless of prio.
  assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid || (prio_q == 1'b0));
  assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || (prio_q == 1'b1));

  assign add_ovf = ({1'b0, op_a} + {1'b0, op_b}) > {1'b0, {WIDTH{1'b1}}};

  pre_alu u_pre_alu (
    .a   (op_a),
    .b   (op_b),
    .sel (op_sel),
    .c   (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q == EXEC) || (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= INIT_PRIO;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= 1'b0;
      op_id     <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_c     <= '0;
      rsp_carry <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        op_a   <= grant1 ? req1_a   : req0_a;
        op_b   <= grant1 ? req1_b   : req0_b;
        op_sel <= grant1 ? req1_sel : req0_sel;
        op_id  <= grant1;
        prio_q <= ~grant1;
      end
      if (state_q == EXEC) begin
        rsp_c  <= alu_c;
        rsp_id <= op_id;
        case (op_sel)
          SEL_ADD: rsp_carry <= add_ovf;
          default: rsp_carry <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - directed self-checking bench for alu_rr_arbiter
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_sel, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_sel, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
  logic [3:0] rsp_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(4), .INIT_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_c      (rsp_c),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a lone request, then walk it through EXEC and RESP to the handshake.
  task automatic single_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                           input logic sel, input logic [3:0] exp_c, input logic exp_carry);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
    #1;
    check_eq("grant_ready", id ? req1_ready : req0_ready, 1);
    check_eq("other_ready", id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("exec_busy", busy, 1);
    check_eq("exec_valid", rsp_valid, 0);
    tick();
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_id", rsp_id, id);
    check_eq("rsp_c", rsp_c, exp_c);
    check_eq("rsp_carry", rsp_carry, exp_carry);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_drop", rsp_valid, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    rsp_ready = 0;
    #12;
    check_eq("rst_valid", rsp_valid, 0);
    check_eq("rst_id", rsp_id, 0);
    check_eq("rst_c", rsp_c, 0);
    check_eq("rst_carry", rsp_carry, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rdy0", req0_ready, 0);
    check_eq("rst_rdy1", req1_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add, overflow add, AND on the same operands
    single_op(1'b0, 4'b0010, 4'b1000, 1'b0, 4'b1010, 1'b0);
    single_op(1'b1, 4'b1111, 4'b0101, 1'b0, 4'b0100, 1'b1);
    single_op(1'b1, 4'b1111, 4'b0101, 1'b1, 4'b0101, 1'b0);

    // rsp_ready with nothing pending has no effect
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("stray_ready_valid", rsp_valid, 0);
    check_eq("stray_ready_busy", busy, 0);

    // Contention: prio is 0 here (last grant went to requester 1)
    req0_valid = 1; req0_a = 4'b1110; req0_b = 4'b0001; req0_sel = 1'b1;
    req1_valid = 1; req1_a = 4'b1110; req1_b = 4'b0001; req1_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      check_eq("cont_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      check_eq("cont_exec_rdy", {req0_ready, req1_ready}, 0);
      tick();
      check_eq("cont_valid", rsp_valid, 1);
      check_eq("cont_id", rsp_id, i % 2);
      check_eq("cont_c", rsp_c, (i % 2 == 0) ? 4'b0000 : 4'b1111);
      check_eq("cont_carry", rsp_carry, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    req0_valid = 0; req1_valid = 0;

    // Backpressure: result held while rsp_ready stays low
    req0_valid = 1; req0_a = 4'b0011; req0_b = 4'b0100; req0_sel = 1'b0;
    tick();
    req0_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req0_a = 4'(i);
      check_eq("bp_valid", rsp_valid, 1);
      check_eq("bp_c", rsp_c, 4'b0111);
      check_eq("bp_id", rsp_id, 0);
      check_eq("bp_busy", busy, 1);
      check_eq("bp_rdy", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_hs_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b0;
    check_eq("bp_after_valid", rsp_valid, 0);

    // req1 pulses valid during RESP, then withdraws before IDLE
    req0_valid = 1; req0_a = 4'b0001; req0_b = 4'b0001; req0_sel = 1'b0;
    tick();
    req0_valid = 0;
    tick();
    req1_valid = 1; req1_a = 4'b1010; req1_b = 4'b0101; req1_sel = 1'b0;
    #1;
    check_eq("wd_rdy1_resp", req1_ready, 0);
    check_eq("wd_c", rsp_c, 4'b0010);
    tick();
    req1_valid = 0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("wd_busy", busy, 0);
      check_eq("wd_valid", rsp_valid, 0);
      tick();
    end

    // Reset in EXEC: prio is 1 after a req0 grant, reset must restore 0
    req0_valid = 1; req0_a = 4'b0101; req0_b = 4'b0101; req0_sel = 1'b0;
    tick();
    req0_valid = 0;
    check_eq("mr_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_busy_async", busy, 0);
    check_eq("mr_valid_async", rsp_valid, 0);
    check_eq("mr_c_async", rsp_c, 0);
    tick();
    check_eq("mr_valid_held", rsp_valid, 0);
    rst_n = 1'b1;
    tick();
    check_eq("mr_no_rsp", rsp_valid, 0);
    req0_valid = 1; req0_a = 4'b0110; req0_b = 4'b0011; req0_sel = 1'b1;
    req1_valid = 1; req1_a = 4'b0110; req1_b = 4'b0011; req1_sel = 1'b0;
    #1;
    check_eq("mr_prio_rdy0", req0_ready, 1);
    check_eq("mr_prio_rdy1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    check_eq("mr_rsp_id", rsp_id, 0);
    check_eq("mr_rsp_c", rsp_c, 4'b0010);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
